// File: rtl/dcache_miss_scheduler_if.sv
// Bundle of handshake and bus signals between the dcache consumers, the
// miss scheduler and the memory controller channels.
//
// master modport : the scheduler's view (consumes cache requests and memory
//                  responses, drives consumer completions and memory requests)
// slave modport  : the environment's view (cache + memory controller)
//
// Consumer side : *_valid/*_address/*_data in, *_ready/read_data out
// Memory side   : *_valid/*_address/write_data out, *_ready/read_data in
interface dcache_miss_scheduler_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
           consumer_write_valid, consumer_write_address, consumer_write_data,
           mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address,
           mem_write_valid, mem_write_address, mem_write_data
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
           consumer_write_valid, consumer_write_address, consumer_write_data,
           mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address,
           mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/dcache_miss_scheduler.sv
// dcache_miss_scheduler: shares NUM_CHANNELS memory-controller channels among
// NUM_CONSUMERS dcache request ports. Idle channels are allocated round-robin
// (one grant per consumer per cycle); each channel relays one read or write
// from request through memory handshake to a single consumer ready pulse.
//
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous, active-high reset
//   bus   - dcache_miss_scheduler_if.master (consumer + memory handshakes)
//   perf_grants, perf_stall_cycles - 16-bit saturating counters, present only
//     when DCACHE_MISS_SCHED_PERF_EN is defined
module dcache_miss_scheduler #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic clk,
  input  logic reset,
  dcache_miss_scheduler_if.master bus
`ifdef DCACHE_MISS_SCHED_PERF_EN
  ,
  output logic [15:0] perf_grants,
  output logic [15:0] perf_stall_cycles
`else
`endif
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } ch_state_t;

  ch_state_t                state      [NUM_CHANNELS];
  ch_state_t                state_next [NUM_CHANNELS];
  logic [CW-1:0]            owner      [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     addr_q     [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     wdata_q    [NUM_CHANNELS];
  logic [CW-1:0]            grant_idx  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  grant;
  logic [NUM_CHANNELS-1:0]  grant_wr;
  logic [NUM_CHANNELS-1:0]  read_done;
  logic [NUM_CHANNELS-1:0]  relay_done;

  logic [NUM_CONSUMERS-1:0]                busy;
  logic [NUM_CONSUMERS-1:0]                pending;
  logic [NUM_CONSUMERS-1:0]                rd_rdy;
  logic [NUM_CONSUMERS-1:0]                wr_rdy;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q;
  logic [CW-1:0]                           rr_ptr;
  logic [CW-1:0]                           rr_next;

  // Ready outputs are decoded from channel state so they fall together with
  // the channel returning to IDLE (and immediately on reset).
  assign pending = (bus.consumer_read_valid | bus.consumer_write_valid)
                   & ~busy & ~rd_rdy & ~wr_rdy;

  // Round-robin allocation: channels in ascending order, each scanning
  // consumers from rr_ptr with wrap; a consumer taken by a lower channel is
  // masked out for the rest of the cycle.
  always_comb begin
    logic [NUM_CONSUMERS-1:0] avail;
    logic [CW:0]              sum;
    logic [CW-1:0]            idx;
    avail    = pending;
    grant    = '0;
    grant_wr = '0;
    rr_next  = rr_ptr;
    sum      = '0;
    idx      = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_idx[ch] = '0;
      if (state[ch] == IDLE) begin
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
          sum = {1'b0, rr_ptr} + (CW+1)'(k);
          if (sum >= (CW+1)'(NUM_CONSUMERS)) sum = sum - (CW+1)'(NUM_CONSUMERS);
          idx = sum[CW-1:0];
          if (!grant[ch] && avail[idx]) begin
            grant[ch]     = 1'b1;
            grant_idx[ch] = idx;
            // read wins when both are requested; the write comes back later
            grant_wr[ch]  = ~bus.consumer_read_valid[idx];
            avail[idx]    = 1'b0;
            sum           = {1'b0, idx} + (CW+1)'(1);
            rr_next       = (sum == (CW+1)'(NUM_CONSUMERS)) ? '0 : sum[CW-1:0];
          end
        end
      end
    end
  end

  // Per-channel next state.
  always_comb begin
    read_done  = '0;
    relay_done = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_next[ch] = state[ch];
      case (state[ch])
        IDLE: begin
          if (grant[ch]) state_next[ch] = grant_wr[ch] ? WRITE_WAIT : READ_WAIT;
        end
        READ_WAIT: begin
          if (bus.mem_read_ready[ch]) begin
            read_done[ch]  = 1'b1;
            state_next[ch] = READ_RELAY;
          end
        end
        WRITE_WAIT: begin
          if (bus.mem_write_ready[ch]) state_next[ch] = WRITE_RELAY;
        end
        READ_RELAY: begin
          if (!bus.consumer_read_valid[owner[ch]]) begin
            relay_done[ch] = 1'b1;
            state_next[ch] = IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!bus.consumer_write_valid[owner[ch]]) begin
            relay_done[ch] = 1'b1;
            state_next[ch] = IDLE;
          end
        end
        default: state_next[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) state[ch] <= IDLE;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) state[ch] <= state_next[ch];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      busy    <= '0;
      rdata_q <= '0;
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        owner[ch]   <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (grant[ch]) begin
          owner[ch]             <= grant_idx[ch];
          busy[grant_idx[ch]]   <= 1'b1;
          if (grant_wr[ch]) begin
            addr_q[ch]  <= bus.consumer_write_address[grant_idx[ch]];
            wdata_q[ch] <= bus.consumer_write_data[grant_idx[ch]];
          end else begin
            addr_q[ch]  <= bus.consumer_read_address[grant_idx[ch]];
          end
        end
        // a relaying consumer is busy, so it cannot also be granted this cycle
        if (relay_done[ch]) busy[owner[ch]] <= 1'b0;
        if (read_done[ch])  rdata_q[owner[ch]] <= bus.mem_read_data[ch];
      end
    end
  end

  always_comb begin
    rd_rdy                = '0;
    wr_rdy                = '0;
    bus.mem_read_valid    = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state[ch])
        READ_WAIT: begin
          bus.mem_read_valid[ch]   = 1'b1;
          bus.mem_read_address[ch] = addr_q[ch];
        end
        WRITE_WAIT: begin
          bus.mem_write_valid[ch]   = 1'b1;
          bus.mem_write_address[ch] = addr_q[ch];
          bus.mem_write_data[ch]    = wdata_q[ch];
        end
        READ_RELAY:  rd_rdy[owner[ch]] = 1'b1;
        WRITE_RELAY: wr_rdy[owner[ch]] = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.consumer_read_ready  = rd_rdy;
  assign bus.consumer_write_ready = wr_rdy;
  assign bus.consumer_read_data   = rdata_q;

`ifdef DCACHE_MISS_SCHED_PERF_EN
  logic        any_idle;
  logic [16:0] grant_sum;

  always_comb begin
    any_idle  = 1'b0;
    grant_sum = {1'b0, perf_grants};
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state[ch] == IDLE) any_idle = 1'b1;
      if (grant[ch]) grant_sum = grant_sum + 17'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grants       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_grants <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
      if ((|pending) && !any_idle && (perf_stall_cycles != 16'hFFFF))
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
    end
  end
`else
`endif

endmodule
